button_irq_ctrl: RTL and testbench
==================================

Name: button_irq_ctrl

Overview:
Parametrised front-panel input controller for the dataloger CPU, generalising the fixed 4-button wiring to N channels. It synchronises and debounces N raw active-low push buttons and latches press events as pending flags. It raises a single prioritised, maskable interrupt request with an index and an acknowledge handshake. It sits between the board button pins and the processor interrupt input.

Parameters:
N_BTN, 4, number of button channels (1..16)
DEBOUNCE_CYCLES, 4, consecutive stable synced samples needed to accept a level change (>=2)
ID_W, 2, width of irq_id; must be >= clog2(N_BTN), minimum 1

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
buttons  in  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk
mask  in  N_BTN  interrupt enable per channel (1 = enabled)
ack  in  1  single-cycle acknowledge of the currently reported irq_id
clear  in  1  single-cycle flush of all pending flags
btn_level  out  N_BTN  debounced level, active-high (1 = pressed)
pending  out  N_BTN  latched press events
irq  out  1  interrupt request, registered
irq_id  out  ID_W  index of the serviced channel, registered

Behaviour:
- Reset (reset=0, asynchronous): synchroniser flops = 1 (released); counters = 0; btn_level = 0; pending = 0; irq = 0; irq_id = 0. Outputs go low immediately, not at the next edge. Release is sampled on the next clk edge.
- Synchroniser: 2 flops per channel. sync = ~stage2 (active-high).
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES):
  - sync == btn_level: counter <= 0.
  - sync != btn_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level toggles, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes btn_level.
- Event: press = btn_level 0->1, detected against a registered copy of btn_level. Release generates no event.
- Pending:
  - Set on press regardless of mask. Masked events stay latched and fire when unmasked.
  - Cleared by ack for channel irq_id, only if irq=1. An ack while irq=0 is ignored.
  - Cleared for all channels by clear.
  - A set in the same cycle as an ack or clear on the same channel wins: pending stays 1.
  - Re-press of an already pending channel: no effect.
- Request: irq <= |(pending & mask). irq_id <= lowest index i with pending[i] & mask[i]. When none, irq_id holds its last value.
  - Both are registered, so they are valid one cycle after pending or mask changes.
  - After an ack, the next pending channel is reported on the cycle after pending clears. irq may stay high continuously.
- Latency, counting from the first clk edge sampling a stable raw press (edge 1):
  - btn_level rises at edge DEBOUNCE_CYCLES+2.
  - pending at +1 edge after that.
  - irq/irq_id at +1 edge after pending.
  - With default parameters: 6 / 7 / 8.
- Simultaneous presses on several channels: all latch, then are serviced lowest-index first.
- Reset mid-debounce: the partial count is discarded. A button held through reset release is re-debounced and generates a press event afterwards.

Test Plan:
1. Defaults, mask=4'b1111, buttons 4'b1111->4'b1110 held 12 cycles -> btn_level[0]=1 at edge 6, pending=4'b0001 at 7, irq=1 irq_id=0 at 8; ack at 9 -> pending=0 at 10, irq=0 at 11.
2. buttons[0] low for 3 cycles only -> btn_level, pending and irq remain 0 throughout.
3. buttons 4'b0101 (channels 1 and 3) pressed together -> irq_id=1. Ack -> irq_id=3 two edges later, irq stays 1. Second ack -> irq=0, pending=0.
4. mask=4'b1011, press button 2 -> pending[2]=1, irq=0. Set mask=4'b1111 -> irq=1 irq_id=2 on the next edge.
5. Channel 0 pending and reported; second press on channel 0 matures in the same cycle as ack -> pending[0] stays 1, irq stays 1. Clear pulse with no new event -> pending=0, irq=0 the edge after.
6. reset driven low at debounce count 2 -> all outputs 0 immediately. Button kept pressed, reset released -> btn_level rises 6 edges after release, one press event generated.

Source files
------------

// File: rtl/button_irq_ctrl.sv
// button_irq_ctrl: front-panel button controller.
// Synchronises and debounces N active-low buttons, latches press events as
// pending flags and raises one prioritised, maskable interrupt with an index
// and an acknowledge handshake.
module button_irq_ctrl #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ID_W            = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] buttons,
    input  logic [N_BTN-1:0] mask,
    input  logic             ack,
    input  logic             clear,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] pending,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id
);

    // A count of DEBOUNCE_CYCLES-1 is the last value before a level change,
    // so the counter only ever has to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_level_d;
    logic [N_BTN-1:0] r_pending;
    logic             r_irq;
    logic [ID_W-1:0]  r_irq_id;
    logic [CNT_W-1:0] r_cnt [N_BTN];

    logic [N_BTN-1:0] w_sync;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_active;
    logic [N_BTN-1:0] w_clr;
    logic [N_BTN-1:0] w_pending_next;
    logic             w_found;
    logic [ID_W-1:0]  w_sel;

    // Two-flop synchroniser; flops reset to the released (high) pin level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync = ~r_sync2;

    // Per-channel debounce: a level change is accepted only after the synced
    // input disagrees with the current level for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (w_sync[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_level[i] <= ~r_level[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced level for rising-edge (press) detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_d <= '0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign w_press  = r_level & ~r_level_d;
    assign w_active = r_pending & mask;

    // Clear vector: clear flushes everything, ack only drops the channel
    // currently being reported and only while a request is actually raised.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_clr[i] = clear | (ack & r_irq & (r_irq_id == ID_W'(i)));
        end
        w_pending_next = (r_pending & ~w_clr) | w_press;
    end

    // Lowest-index enabled pending channel; scanning downwards lets the
    // lowest match overwrite any higher one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_found = 1'b1;
                w_sel   = ID_W'(i);
            end
        end
    end

    // Pending flags and the registered request; irq_id holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_irq     <= w_found;
            if (w_found) begin
                r_irq_id <= w_sel;
            end
        end
    end

    assign btn_level = r_level;
    assign pending   = r_pending;
    assign irq       = r_irq;
    assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_button_irq_ctrl.sv
// tb_button_irq_ctrl: directed self-checking bench for button_irq_ctrl with
// default parameters. A vector table covers the basic press/ack and glitch
// cases; hand sequences cover masking, set-vs-ack, clear and reset.
module tb_button_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] buttons;
    logic [3:0] mask;
    logic       ack;
    logic       clear;
    logic [3:0] btn_level;
    logic [3:0] pending;
    logic       irq;
    logic [1:0] irq_id;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] msk;
        logic       ack;
        logic       clr;
        logic [3:0] expLevel;
        logic [3:0] expPend;
        logic       expIrq;
        logic [1:0] expId;
    } vec_t;

    vec_t vecs[$];

    button_irq_ctrl #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4),
        .ID_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buttons(buttons),
        .mask(mask),
        .ack(ack),
        .clear(clear),
        .btn_level(btn_level),
        .pending(pending),
        .irq(irq),
        .irq_id(irq_id)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic [3:0] m,
                                 input logic a, input logic c);
        buttons = b;
        mask    = m;
        ack     = a;
        clear   = c;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eLevel,
                               input logic [3:0] ePend, input logic eIrq,
                               input logic [1:0] eId);
        vecCount++;
        if (btn_level !== eLevel || pending !== ePend || irq !== eIrq || irq_id !== eId) begin
            missCount++;
            $display("[TB] FAIL %s: got level=%b pending=%b irq=%b id=%0d, expected level=%b pending=%b irq=%b id=%0d",
                     name, btn_level, pending, irq, irq_id, eLevel, ePend, eIrq, eId);
        end
    endtask

    task automatic addVec(input logic [3:0] b, input logic a, input logic [3:0] eL,
                          input logic [3:0] eP, input logic eI, input logic [1:0] eId);
        vec_t v;
        v.btn = b; v.msk = 4'b1111; v.ack = a; v.clr = 1'b0;
        v.expLevel = eL; v.expPend = eP; v.expIrq = eI; v.expId = eId;
        vecs.push_back(v);
    endtask

    initial begin
        // Basic press on channel 0: level at edge 6, pending 7, irq 8, then ack.
        for (int k = 0; k < 5; k++) addVec(4'b1110, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        addVec(4'b1110, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
        addVec(4'b1110, 1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0);
        addVec(4'b1110, 1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0);
        addVec(4'b1110, 1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0);
        addVec(4'b1110, 1'b1, 4'b0001, 4'b0000, 1'b1, 2'd0);
        addVec(4'b1110, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
        addVec(4'b1110, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
        // Release: level falls six edges later, no event.
        for (int k = 0; k < 5; k++) addVec(4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
        addVec(4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        // Three-cycle glitch on channel 0 must be filtered out.
        for (int k = 0; k < 3; k++) addVec(4'b1110, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        for (int k = 0; k < 8; k++) addVec(4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);

        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
        reset = 1'b1;
        #3 reset = 1'b0;
        #1 checkOutput("reset_state", 4'b0000, 4'b0000, 1'b0, 2'd0);
        ticks(2);
        reset = 1'b1;
        ticks(3);
        checkOutput("idle_after_reset", 4'b0000, 4'b0000, 1'b0, 2'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].btn, vecs[k].msk, vecs[k].ack, vecs[k].clr);
            tick();
            checkOutput($sformatf("table_%0d", k), vecs[k].expLevel, vecs[k].expPend,
                        vecs[k].expIrq, vecs[k].expId);
        end

        // Channels 1 and 3 together, serviced lowest first.
        applyStimulus(4'b0101, 4'b1111, 1'b0, 1'b0);
        ticks(6); checkOutput("multi_level", 4'b1010, 4'b0000, 1'b0, 2'd0);
        tick();   checkOutput("multi_pend", 4'b1010, 4'b1010, 1'b0, 2'd0);
        tick();   checkOutput("multi_irq1", 4'b1010, 4'b1010, 1'b1, 2'd1);
        ack = 1'b1; tick(); checkOutput("multi_ack1", 4'b1010, 4'b1000, 1'b1, 2'd1);
        ack = 1'b0; tick(); checkOutput("multi_irq3", 4'b1010, 4'b1000, 1'b1, 2'd3);
        ack = 1'b1; tick(); checkOutput("multi_ack3", 4'b1010, 4'b0000, 1'b1, 2'd3);
        ack = 1'b0; tick(); checkOutput("multi_idle", 4'b1010, 4'b0000, 1'b0, 2'd3);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
        ticks(8); checkOutput("multi_release", 4'b0000, 4'b0000, 1'b0, 2'd3);

        // Masked channel 2 stays pending, stray ack ignored, fires on unmask.
        applyStimulus(4'b1011, 4'b1011, 1'b0, 1'b0);
        ticks(7); checkOutput("mask_pend", 4'b0100, 4'b0100, 1'b0, 2'd3);
        tick();   checkOutput("mask_noirq", 4'b0100, 4'b0100, 1'b0, 2'd3);
        ack = 1'b1; tick(); checkOutput("mask_stray_ack", 4'b0100, 4'b0100, 1'b0, 2'd3);
        ack = 1'b0; mask = 4'b1111;
        tick();   checkOutput("mask_unmask", 4'b0100, 4'b0100, 1'b1, 2'd2);
        ack = 1'b1; tick(); checkOutput("mask_ack", 4'b0100, 4'b0000, 1'b1, 2'd2);
        ack = 1'b0; tick(); checkOutput("mask_idle", 4'b0100, 4'b0000, 1'b0, 2'd2);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
        ticks(8); checkOutput("mask_release", 4'b0000, 4'b0000, 1'b0, 2'd2);

        // Re-press of channel 0 maturing in the same cycle as its ack, then clear.
        applyStimulus(4'b1110, 4'b1111, 1'b0, 1'b0);
        ticks(7); checkOutput("set_pend", 4'b0001, 4'b0001, 1'b0, 2'd2);
        tick();   checkOutput("set_irq", 4'b0001, 4'b0001, 1'b1, 2'd0);
        buttons = 4'b1111;
        ticks(6); checkOutput("set_released", 4'b0000, 4'b0001, 1'b1, 2'd0);
        buttons = 4'b1110;
        ticks(6); checkOutput("set_repress", 4'b0001, 4'b0001, 1'b1, 2'd0);
        ack = 1'b1; tick(); checkOutput("set_wins_ack", 4'b0001, 4'b0001, 1'b1, 2'd0);
        ack = 1'b0; tick(); checkOutput("set_still_irq", 4'b0001, 4'b0001, 1'b1, 2'd0);
        clear = 1'b1; tick(); checkOutput("clear_pend", 4'b0001, 4'b0000, 1'b1, 2'd0);
        clear = 1'b0; tick(); checkOutput("clear_irq", 4'b0001, 4'b0000, 1'b0, 2'd0);
        buttons = 4'b1111;
        ticks(8); checkOutput("clear_release", 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Reset mid-debounce with channels 3 and 0 held through release.
        applyStimulus(4'b0111, 4'b1111, 1'b0, 1'b0);
        ticks(7); checkOutput("rst_pre_pend", 4'b1000, 4'b1000, 1'b0, 2'd0);
        tick();   checkOutput("rst_pre_irq", 4'b1000, 4'b1000, 1'b1, 2'd3);
        buttons = 4'b0110;
        ticks(4);
        reset = 1'b0;
        #2 checkOutput("rst_immediate", 4'b0000, 4'b0000, 1'b0, 2'd0);
        ticks(2);
        reset = 1'b1;
        ticks(5); checkOutput("rst_redebounce", 4'b0000, 4'b0000, 1'b0, 2'd0);
        tick();   checkOutput("rst_level", 4'b1001, 4'b0000, 1'b0, 2'd0);
        tick();   checkOutput("rst_pend", 4'b1001, 4'b1001, 1'b0, 2'd0);
        tick();   checkOutput("rst_irq", 4'b1001, 4'b1001, 1'b1, 2'd0);
        ack = 1'b1; tick(); checkOutput("rst_ack0", 4'b1001, 4'b1000, 1'b1, 2'd0);
        ack = 1'b0; tick(); checkOutput("rst_irq3", 4'b1001, 4'b1000, 1'b1, 2'd3);
        ack = 1'b1; tick(); checkOutput("rst_ack3", 4'b1001, 4'b0000, 1'b1, 2'd3);
        ack = 1'b0; tick(); checkOutput("rst_idle", 4'b1001, 4'b0000, 1'b0, 2'd3);
        ticks(4); checkOutput("rst_single_event", 4'b1001, 4'b0000, 1'b0, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
